fft_writeback_ctrl: RTL and testbench

Drains the FFT accelerator's 512-bit result FIFO and turns each result line into a cache-line write request toward host memory, with addresses generated from a programmed base. Sits directly downstream of the FFT user block: it owns that block's output-FIFO read port. It also tracks write completions and signals job completion after `ctx_length` lines have been written and acknowledged.

---
 rtl/fft_writeback_ctrl.sv | 145 ++++++++++++++
 tb/tb_fft_writeback_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_writeback_ctrl.sv
// fft_writeback_ctrl
//   Drains the FFT result FIFO (512-bit lines) and issues one cache-line write
//   request per line toward host memory. Line addresses are the programmed
//   base plus the line index, wrapping modulo 2^ADDR_WIDTH. Write completions
//   are counted, and a one-cycle done pulse is raised once every line of the
//   job has been issued and acknowledged.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : one-cycle job start pulse (accepted only when idle)
//   dst_base_addr       : cache-line address of the first result line
//   ctx_length          : number of lines in the job
//   output_fifo_dout    : result FIFO data, valid the cycle after a read
//   output_fifo_empty   : result FIFO empty flag
//   output_fifo_re      : result FIFO read enable (combinational)
//   wr_req_valid/addr/data : write request, one line per cycle
//   wr_req_almostfull   : write channel backpressure
//   wr_rsp_valid        : one write completion per asserted cycle
//   busy                : job in progress
//   done                : one-cycle job completion pulse
module fft_writeback_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_base_addr,
  input  logic [CNT_WIDTH-1:0]  ctx_length,
  input  logic [511:0]          output_fifo_dout,
  input  logic                  output_fifo_empty,
  output logic                  output_fifo_re,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [511:0]          wr_req_data,
  input  logic                  wr_req_almostfull,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic                  re;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  // Line address = base + index, wrapping at the address width.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [CNT_WIDTH-1:0]  idx
  );
    return base + ADDR_WIDTH'(idx);
  endfunction

  // The reset term keeps the FIFO from popping a line that the abort would
  // otherwise lose.
  assign re = (state_q == ST_RUN) && !output_fifo_empty && !wr_req_almostfull &&
              (issue_cnt_q < len_q) && !reset;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          base_d      = dst_base_addr;
          len_d       = ctx_length;
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        issue_cnt_d = issue_cnt_q + CNT_WIDTH'(re);
        rsp_cnt_d   = rsp_cnt_q + CNT_WIDTH'(wr_rsp_valid);
        // Leave as soon as the last line is issued; skip DRAIN when every
        // completion is already in (covers zero-length jobs).
        if (issue_cnt_d >= len_q) begin
          state_d = (rsp_cnt_d == len_q) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rsp_cnt_d = rsp_cnt_q + CNT_WIDTH'(wr_rsp_valid);
        if (rsp_cnt_d == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      // p0 -> p1: the read cycle launches the request; its address is taken
      // from the issue count before that count advances.
      vld_p1      <= re;
      if (re) begin
        addr_p1 <= line_addr(base_q, issue_cnt_q);
      end
    end
  end

  // p1: request stage. The FIFO's own read register delivers the line in this
  // cycle, so it forms the data register; the bus is held at zero otherwise.
  assign output_fifo_re = re;
  assign wr_req_valid   = vld_p1;
  assign wr_req_addr    = addr_p1;
  assign wr_req_data    = vld_p1 ? output_fifo_dout : '0;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_writeback_ctrl.sv
// Testbench for fft_writeback_ctrl: a result FIFO and a write-response
// responder surround the DUT, and a job-level reference model predicts every
// output on every cycle. Directed jobs add literal expectations on top.
module tb_fft_writeback_ctrl;
  localparam int AW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] dst_base_addr;
  logic [CW-1:0] ctx_length;
  logic [511:0]  output_fifo_dout;
  logic          output_fifo_empty;
  logic          output_fifo_re;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [511:0]  wr_req_data;
  logic          wr_req_almostfull;
  logic          wr_rsp_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fft_writeback_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .dst_base_addr     (dst_base_addr),
    .ctx_length        (ctx_length),
    .output_fifo_dout  (output_fifo_dout),
    .output_fifo_empty (output_fifo_empty),
    .output_fifo_re    (output_fifo_re),
    .wr_req_valid      (wr_req_valid),
    .wr_req_addr       (wr_req_addr),
    .wr_req_data       (wr_req_data),
    .wr_req_almostfull (wr_req_almostfull),
    .wr_rsp_valid      (wr_rsp_valid),
    .busy              (busy),
    .done              (done)
  );

  // Result FIFO contents (synchronous read) and responder state.
  logic [511:0] fifo_mem [0:127];
  int           wp = 0;
  int           rp = 0;
  int           cyc = 0;
  int           rsp_delay = 1;
  int           rsp_due [$];

  assign output_fifo_empty = (wp == rp);

  int n_checks = 0;
  int n_fail   = 0;

  // Observation logs.
  logic [AW-1:0]  req_addr_log [$];
  logic [511:0]   req_data_log [$];
  int             req_cyc_log  [$];
  int             re_cnt       = 0;
  int             done_cyc     = -1;
  int             last_rsp_cyc = -1;
  int             start_cyc    = 0;
  bit             got_done     = 0;

  // Reference model: a job is active from the cycle after an accepted start
  // until it has issued and seen acknowledged all of its lines.
  bit             m_known  = 0;
  bit             m_active = 0;
  bit             m_done   = 0;
  bit             m_vld    = 0;
  bit             m_zero   = 0;
  logic [AW-1:0]  m_base   = '0;
  logic [CW-1:0]  m_len    = '0;
  int unsigned    m_issued = 0;
  int unsigned    m_rsp    = 0;
  int             m_rp     = 0;
  logic [AW-1:0]  m_exp_addr = '0;
  logic [511:0]   m_exp_data = '0;

  function automatic logic [511:0] line(input int job, input int idx);
    logic [15:0] j16;
    logic [15:0] i16;
    j16 = job[15:0];
    i16 = idx[15:0];
    return {16{j16, i16}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_line(input logic [511:0] d);
    fifo_mem[wp % 128] = d;
    wp++;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // update FIFO data and responses just after the rising edge.
  task automatic tick();
    bit   exp_re;
    logic re_now;
    logic vld_now;
    @(negedge clk);
    exp_re = m_known && m_active && !reset && (wp - m_rp > 0) &&
             !wr_req_almostfull && (m_issued < m_len);
    if (m_known) begin
      check("fifo_re", output_fifo_re, exp_re);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("req_valid", wr_req_valid, m_vld);
      if (m_vld) begin
        check("req_addr", wr_req_addr, m_exp_addr);
        check("req_data", wr_req_data, m_exp_data);
      end
      if (m_zero) begin
        check("reset_addr", wr_req_addr, 0);
        check("reset_data", wr_req_data, 0);
      end
    end
    if (output_fifo_re === 1'b1) re_cnt++;
    if (wr_req_valid === 1'b1) begin
      req_addr_log.push_back(wr_req_addr);
      req_data_log.push_back(wr_req_data);
      req_cyc_log.push_back(cyc);
    end
    if (done === 1'b1) begin
      got_done = 1;
      done_cyc = cyc;
    end
    if (wr_rsp_valid) last_rsp_cyc = cyc;

    if (reset) begin
      m_known  = 1;
      m_active = 0;
      m_done   = 0;
      m_vld    = 0;
      m_zero   = 1;
      m_issued = 0;
      m_rsp    = 0;
    end else begin
      m_zero = 0;
      m_vld  = exp_re;
      if (exp_re) begin
        m_exp_addr = m_base + m_issued;
        m_exp_data = fifo_mem[m_rp % 128];
        m_rp++;
      end
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active  = 1;
          m_base    = dst_base_addr;
          m_len     = ctx_length;
          m_issued  = 0;
          m_rsp     = 0;
          start_cyc = cyc;
        end
      end else begin
        if (exp_re) m_issued++;
        if (wr_rsp_valid) m_rsp++;
        if (m_issued >= m_len && m_rsp == m_len) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end

    re_now  = output_fifo_re;
    vld_now = wr_req_valid;
    @(posedge clk);
    cyc++;
    #1;
    if (re_now === 1'b1) begin
      output_fifo_dout = fifo_mem[rp % 128];
      rp++;
    end
    if (vld_now === 1'b1) rsp_due.push_back(cyc - 1 + rsp_delay);
    if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      wr_rsp_valid = 1'b1;
      void'(rsp_due.pop_front());
    end else begin
      wr_rsp_valid = 1'b0;
    end
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [CW-1:0] len);
    dst_base_addr = base;
    ctx_length    = len;
    start         = 1'b1;
    got_done      = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !got_done; i++) tick();
    check({name, "_done_seen"}, got_done, 1);
  endtask

  initial begin
    int            idx;
    int            r0;
    int            r1;
    int            sc;
    logic [AW-1:0] wrap_exp [4];

    reset             = 1'b1;
    start             = 1'b0;
    dst_base_addr     = '0;
    ctx_length        = '0;
    output_fifo_dout  = '0;
    wr_req_almostfull = 1'b0;
    wr_rsp_valid      = 1'b0;

    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("idle_no_reads", re_cnt, 0);

    // Basic job: 4 preloaded lines, immediate responses.
    for (int i = 0; i < 4; i++) push_line(line(1, i));
    idx = req_addr_log.size();
    start_job(32'h1000, 4);
    wait_done("basic", 40);
    check("basic_count", req_addr_log.size() - idx, 4);
    for (int i = 0; i < 4; i++) check("basic_addr", req_addr_log[idx + i], 32'h1000 + i);
    check("basic_data0", req_data_log[idx], {16{32'h0001_0000}});
    check("basic_data3", req_data_log[idx + 3], {16{32'h0001_0003}});
    check("basic_first_req_cycle", req_cyc_log[idx], start_cyc + 2);
    check("basic_back_to_back", req_cyc_log[idx + 3], start_cyc + 5);
    check("basic_done_after_rsp", done_cyc, last_rsp_cyc + 1);
    repeat (2) tick();

    // Backpressure: almostfull for 5 cycles after the 2nd read.
    for (int i = 0; i < 8; i++) push_line(line(2, i));
    idx = req_addr_log.size();
    r0  = re_cnt;
    start_job(32'h2000, 8);
    for (int i = 0; i < 20 && (re_cnt - r0) < 2; i++) tick();
    wr_req_almostfull = 1'b1;
    r1 = re_cnt;
    repeat (5) tick();
    check("bp_no_reads_while_full", re_cnt - r1, 0);
    wr_req_almostfull = 1'b0;
    wait_done("bp", 60);
    check("bp_count", req_addr_log.size() - idx, 8);
    for (int i = 0; i < 8; i++) check("bp_addr", req_addr_log[idx + i], 32'h2000 + i);
    check("bp_data7", req_data_log[idx + 7], {16{32'h0002_0007}});
    repeat (2) tick();

    // Bursty FIFO: one line every 3rd cycle.
    idx = req_addr_log.size();
    r0  = re_cnt;
    start_job(32'h3000, 6);
    for (int i = 0; i < 6; i++) begin
      push_line(line(3, i));
      repeat (3) tick();
    end
    wait_done("burst", 40);
    check("burst_count", req_addr_log.size() - idx, 6);
    check("burst_reads", re_cnt - r0, 6);
    check("burst_last_addr", req_addr_log[idx + 5], 32'h3005);
    repeat (2) tick();

    // Zero-length job.
    idx = req_addr_log.size();
    r0  = re_cnt;
    start_job(32'h4000, 0);
    wait_done("zero", 10);
    check("zero_done_cycle", done_cyc, start_cyc + 2);
    check("zero_reads", re_cnt - r0, 0);
    check("zero_reqs", req_addr_log.size() - idx, 0);
    repeat (2) tick();

    // Address wrap.
    wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    for (int i = 0; i < 4; i++) push_line(line(5, i));
    idx = req_addr_log.size();
    start_job(32'hFFFF_FFFE, 4);
    wait_done("wrap", 40);
    check("wrap_count", req_addr_log.size() - idx, 4);
    for (int i = 0; i < 4; i++) check("wrap_addr", req_addr_log[idx + i], wrap_exp[i]);
    repeat (2) tick();

    // Late responses; a start during DRAIN is ignored.
    rsp_delay = 10;
    for (int i = 0; i < 3; i++) push_line(line(6, i));
    idx = req_addr_log.size();
    start_job(32'h5000, 3);
    sc = start_cyc;
    repeat (6) tick();
    check("late_busy_in_drain", busy, 1);
    check("late_all_issued", req_addr_log.size() - idx, 3);
    dst_base_addr = 32'h9000;
    ctx_length    = 5;
    start         = 1'b1;
    tick();
    start = 1'b0;
    wait_done("late", 40);
    check("late_start_ignored", start_cyc, sc);
    check("late_done_after_rsp", done_cyc, last_rsp_cyc + 1);
    check("late_count", req_addr_log.size() - idx, 3);
    rsp_delay = 1;
    repeat (3) tick();
    check("late_idle_after", busy, 0);

    // Reset in the middle of a job, then a fresh job.
    for (int i = 0; i < 8; i++) push_line(line(7, i));
    idx = req_addr_log.size();
    start_job(32'h6000, 8);
    for (int i = 0; i < 20 && (req_addr_log.size() - idx) < 2; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", wr_req_valid, 0);
    check("rst_re", output_fifo_re, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", wr_req_addr, 0);
    check("rst_data", wr_req_data, 0);
    repeat (15) tick();
    for (int i = 0; i < 4; i++) push_line(line(8, i));
    idx = req_addr_log.size();
    start_job(32'h7000, 4);
    wait_done("after_rst", 40);
    check("after_rst_count", req_addr_log.size() - idx, 4);
    check("after_rst_addr0", req_addr_log[idx], 32'h7000);
    check("after_rst_addr3", req_addr_log[idx + 3], 32'h7003);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
